// File: rtl/gpu_ucode_store.sv
// Writable, double-banked GPU microcode control store.
// After reset an init sequence writes NOP_UOP to every entry of both banks, one entry per cycle.
// The sequencer then fetches from the active bank. Fetch results are registered, so a fetch
// accepted on one edge appears on the outputs after that edge. The CPU or boot logic can patch
// either bank through the load port, and a swap pulse changes the active bank atomically.
//
// Ports:
//   iClock, iReset             clock; asynchronous active-high reset
//   iFetchValid/iFetchAddr     fetch request from the sequencer
//   iHold                      sequencer stall; freezes oUop/oUopValid/oFetchErr
//   oFetchReady                fetch accepted when iFetchValid & oFetchReady
//   oUop/oUopValid/oFetchErr   registered fetch result; oFetchErr marks an addr >= DEPTH
//   iLoadValid/iLoadBank/iLoadAddr/iLoadData, oLoadReady   write port, either bank
//   iSwapBank                  pulse: toggle the active bank
//   oActiveBank                bank used for fetch
//   oInitDone                  high once the init clear has finished
module gpu_ucode_store #(
    parameter int unsigned          UOP_WIDTH  = 20,
    parameter int unsigned          ADDR_WIDTH = 8,
    parameter int unsigned          DEPTH      = 256,
    parameter logic [UOP_WIDTH-1:0] NOP_UOP    = '0
) (
    input  logic                  iClock,
    input  logic                  iReset,
    input  logic                  iFetchValid,
    input  logic [ADDR_WIDTH-1:0] iFetchAddr,
    input  logic                  iHold,
    output logic                  oFetchReady,
    output logic [UOP_WIDTH-1:0]  oUop,
    output logic                  oUopValid,
    output logic                  oFetchErr,
    input  logic                  iLoadValid,
    input  logic                  iLoadBank,
    input  logic [ADDR_WIDTH-1:0] iLoadAddr,
    input  logic [UOP_WIDTH-1:0]  iLoadData,
    output logic                  oLoadReady,
    input  logic                  iSwapBank,
    output logic                  oActiveBank,
    output logic                  oInitDone
);

    localparam int unsigned         IdxW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0] DepthW = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [0:0] {StInit, StRun} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH:0]    clr_ptr_q, clr_ptr_d;
    logic                   active_q, active_d;
    logic [UOP_WIDTH-1:0]   uop_q, uop_d;
    logic                   uop_valid_q, uop_valid_d;
    logic                   fetch_err_q, fetch_err_d;

    logic [UOP_WIDTH-1:0]   mem_q [2][DEPTH];

    logic                   run;
    logic                   fetch_acc;
    logic                   load_acc;
    logic                   fetch_in_range;
    logic                   load_in_range;
    logic                   load_hit;
    logic [IdxW-1:0]        fetch_idx;
    logic [IdxW-1:0]        load_idx;
    logic [IdxW-1:0]        clr_idx;

    assign run            = (state_q == StRun);
    assign fetch_acc      = run & iFetchValid & ~iHold;
    assign load_acc       = run & iLoadValid;
    assign fetch_in_range = ({1'b0, iFetchAddr} < DepthW);
    assign load_in_range  = ({1'b0, iLoadAddr} < DepthW);
    assign fetch_idx      = iFetchAddr[IdxW-1:0];
    assign load_idx       = iLoadAddr[IdxW-1:0];
    assign clr_idx        = clr_ptr_q[IdxW-1:0];

    // A load landing on the entry being fetched from the active bank forwards its data.
    assign load_hit = load_acc & load_in_range & (iLoadBank == active_q)
                    & (iLoadAddr == iFetchAddr);

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        active_d    = active_q;
        uop_d       = uop_q;
        uop_valid_d = uop_valid_q;
        fetch_err_d = fetch_err_q;

        unique case (state_q)
            StInit: begin
                clr_ptr_d = clr_ptr_q + 1'b1;
                if (clr_ptr_q == DepthW - 1'b1) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // The swap takes effect after this edge; a same-edge fetch reads the old bank.
                if (iSwapBank) begin
                    active_d = ~active_q;
                end
            end
            default: state_d = StInit;
        endcase

        if (!iHold) begin
            if (fetch_acc) begin
                uop_valid_d = 1'b1;
                if (!fetch_in_range) begin
                    uop_d       = NOP_UOP;
                    fetch_err_d = 1'b1;
                end else if (load_hit) begin
                    uop_d       = iLoadData;
                    fetch_err_d = 1'b0;
                end else begin
                    uop_d       = mem_q[active_q][fetch_idx];
                    fetch_err_d = 1'b0;
                end
            end else begin
                uop_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q     <= StInit;
            clr_ptr_q   <= '0;
            active_q    <= 1'b0;
            uop_q       <= NOP_UOP;
            uop_valid_q <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            active_q    <= active_d;
            uop_q       <= uop_d;
            uop_valid_q <= uop_valid_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Storage has no reset; the init sequence clears it instead. Out-of-range loads are dropped.
    always_ff @(posedge iClock) begin
        if (state_q == StInit) begin
            mem_q[0][clr_idx] <= NOP_UOP;
            mem_q[1][clr_idx] <= NOP_UOP;
        end else if (load_acc && load_in_range) begin
            mem_q[iLoadBank][load_idx] <= iLoadData;
        end
    end

    assign oFetchReady = run & ~iHold;
    assign oLoadReady  = run;
    assign oInitDone   = run;
    assign oActiveBank = active_q;
    assign oUop        = uop_q;
    assign oUopValid   = uop_valid_q;
    assign oFetchErr   = fetch_err_q;

endmodule

// File: tb/tb_gpu_ucode_store.sv
// Self-checking bench for gpu_ucode_store with DEPTH=32: directed scenarios plus a randomized
// run compared against a behavioural model of the store.
module tb_gpu_ucode_store;

    localparam int UW = 20;
    localparam int AW = 8;
    localparam int D  = 32;
    localparam logic [UW-1:0] NOP = 20'h0;

    logic          clk = 1'b0;
    logic          rst;
    logic          fv;
    logic [AW-1:0] fad;
    logic          hold;
    logic          fready;
    logic [UW-1:0] uop;
    logic          uval;
    logic          ferr;
    logic          lv;
    logic          lb;
    logic [AW-1:0] lad;
    logic [UW-1:0] ld;
    logic          lready;
    logic          sw;
    logic          act;
    logic          done;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    logic [UW-1:0] m_mem [2][D];
    bit            m_act;
    bit            m_done;
    int            m_cnt;
    logic [UW-1:0] e_uop;
    bit            e_val;
    bit            e_err;

    gpu_ucode_store #(
        .UOP_WIDTH (UW),
        .ADDR_WIDTH(AW),
        .DEPTH     (D),
        .NOP_UOP   (NOP)
    ) dut (
        .iClock     (clk),
        .iReset     (rst),
        .iFetchValid(fv),
        .iFetchAddr (fad),
        .iHold      (hold),
        .oFetchReady(fready),
        .oUop       (uop),
        .oUopValid  (uval),
        .oFetchErr  (ferr),
        .iLoadValid (lv),
        .iLoadBank  (lb),
        .iLoadAddr  (lad),
        .iLoadData  (ld),
        .oLoadReady (lready),
        .iSwapBank  (sw),
        .oActiveBank(act),
        .oInitDone  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic idle();
        fv   = 1'b0;
        fad  = '0;
        hold = 1'b0;
        lv   = 1'b0;
        lb   = 1'b0;
        lad  = '0;
        ld   = '0;
        sw   = 1'b0;
    endtask

    task automatic m_reset();
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < D; a++) m_mem[b][a] = NOP;
        m_act  = 1'b0;
        m_done = 1'b0;
        m_cnt  = 0;
        e_uop  = NOP;
        e_val  = 1'b0;
        e_err  = 1'b0;
    endtask

    // Advance the model by one edge with the current inputs, then clock the DUT.
    task automatic step();
        if (!m_done) begin
            m_cnt++;
            if (m_cnt == D) m_done = 1'b1;
            if (!hold) e_val = 1'b0;
        end else begin
            if (lv && int'(lad) < D) m_mem[lb][lad] = ld;
            if (!hold) begin
                if (fv) begin
                    e_val = 1'b1;
                    if (int'(fad) >= D) begin
                        e_uop = NOP;
                        e_err = 1'b1;
                    end else begin
                        e_uop = m_mem[m_act][fad];
                        e_err = 1'b0;
                    end
                end else begin
                    e_val = 1'b0;
                end
            end
            if (sw) m_act = ~m_act;
        end
        @(posedge clk);
        #1;
    endtask

    // Assert reset mid-cycle and check the outputs before any clock edge.
    task automatic reset_and_check(input string tag);
        rst = 1'b1;
        #1;
        checks++;
        if ({uop, uval, ferr, fready, lready, act, done} !== {NOP, 6'b0}) begin
            errors++;
            $display("FAIL %s reset outputs: got uop=%h val=%b err=%b fr=%b lr=%b act=%b done=%b, want all zero",
                     tag, uop, uval, ferr, fready, lready, act, done);
        end
        m_reset();
        #2;
        rst = 1'b0;
    endtask

    // Run the init sequence and check the oInitDone timing and that inputs are ignored.
    task automatic check_init(input string tag, input bit noisy);
        for (int i = 0; i < D; i++) begin
            if (noisy) begin
                fv  = 1'b1;
                fad = AW'(i);
                lv  = 1'b1;
                lb  = i[0];
                lad = '0;
                ld  = 20'hFFFFF;
                sw  = 1'b1;
            end
            step();
            checks++;
            if (done !== (i >= D - 1) || lready !== (i >= D - 1) || act !== 1'b0 || uval !== 1'b0) begin
                errors++;
                $display("FAIL %s init cycle %0d: got done=%b lr=%b act=%b val=%b, want done=%b lr=%b act=0 val=0",
                         tag, i, done, lready, act, uval, i >= D - 1, i >= D - 1);
            end
        end
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        m_reset();
        #12;
        checks++;
        if ({uop, uval, ferr, fready, lready, act, done} !== {NOP, 6'b0}) begin
            errors++;
            $display("FAIL reset_state: got uop=%h val=%b err=%b fr=%b lr=%b act=%b done=%b, want all zero",
                     uop, uval, ferr, fready, lready, act, done);
        end
        rst = 1'b0;
        check_init("reset", 1'b1);
    endtask

    task automatic test_init_clear();
        for (int b = 0; b < 2; b++) begin
            for (int a = 0; a < D; a++) begin
                fv  = 1'b1;
                fad = AW'(a);
                step();
                checks++;
                if (uop !== NOP || uval !== 1'b1 || ferr !== 1'b0 || act !== b[0]) begin
                    errors++;
                    $display("FAIL init_clear bank%0d addr%0d: got uop=%h val=%b err=%b act=%b, want %h 1 0 %0d",
                             b, a, uop, uval, ferr, act, NOP, b);
                end
            end
            idle();
            sw = 1'b1;
            step();
            idle();
        end
    endtask

    task automatic test_load_fetch();
        lv  = 1'b1;
        lb  = 1'b0;
        lad = 8'd5;
        ld  = 20'hABCDE;
        step();
        idle();
        fv  = 1'b1;
        fad = 8'd5;
        step();
        idle();
        checks++;
        if (uop !== 20'hABCDE || uval !== 1'b1 || ferr !== 1'b0) begin
            errors++;
            $display("FAIL load_fetch: got uop=%h val=%b err=%b, want abcde 1 0", uop, uval, ferr);
        end
        step();
        checks++;
        if (uval !== 1'b0 || uop !== 20'hABCDE) begin
            errors++;
            $display("FAIL idle_after_fetch: got uop=%h val=%b, want abcde 0", uop, uval);
        end
    endtask

    task automatic test_collision();
        lv  = 1'b1;
        lb  = 1'b0;
        lad = 8'd7;
        ld  = 20'h12345;
        fv  = 1'b1;
        fad = 8'd7;
        step();
        idle();
        checks++;
        if (uop !== 20'h12345 || uval !== 1'b1) begin
            errors++;
            $display("FAIL collision: got uop=%h val=%b, want 12345 1", uop, uval);
        end
        // Same address in the inactive bank must not forward.
        lv  = 1'b1;
        lb  = 1'b1;
        lad = 8'd5;
        ld  = 20'h55555;
        fv  = 1'b1;
        fad = 8'd5;
        step();
        idle();
        checks++;
        if (uop !== 20'hABCDE) begin
            errors++;
            $display("FAIL collision_other_bank: got uop=%h, want abcde", uop);
        end
    endtask

    task automatic test_swap();
        lv  = 1'b1;
        lb  = 1'b1;
        lad = 8'd3;
        ld  = 20'h00F0F;
        step();
        idle();
        sw  = 1'b1;
        fv  = 1'b1;
        fad = 8'd3;
        step();
        idle();
        checks++;
        if (uop !== NOP || act !== 1'b1) begin
            errors++;
            $display("FAIL swap_same_edge: got uop=%h act=%b, want %h 1", uop, act, NOP);
        end
        fv  = 1'b1;
        fad = 8'd3;
        step();
        idle();
        checks++;
        if (uop !== 20'h00F0F || act !== 1'b1) begin
            errors++;
            $display("FAIL swap_new_bank: got uop=%h act=%b, want 00f0f 1", uop, act);
        end
    endtask

    task automatic test_hold_oob();
        sw = 1'b1;
        step();
        idle();
        fv  = 1'b1;
        fad = 8'd5;
        step();
        checks++;
        if (uop !== 20'hABCDE || act !== 1'b0) begin
            errors++;
            $display("FAIL hold_setup: got uop=%h act=%b, want abcde 0", uop, act);
        end
        hold = 1'b1;
        fad  = 8'd7;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (fready !== 1'b0 || uop !== 20'hABCDE || uval !== 1'b1 || ferr !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got fr=%b uop=%h val=%b err=%b, want 0 abcde 1 0",
                         i, fready, uop, uval, ferr);
            end
        end
        hold = 1'b0;
        fad  = 8'd40;
        step();
        idle();
        checks++;
        if (uop !== NOP || uval !== 1'b1 || ferr !== 1'b1) begin
            errors++;
            $display("FAIL oob_fetch: got uop=%h val=%b err=%b, want %h 1 1", uop, uval, ferr, NOP);
        end
        fv  = 1'b1;
        fad = 8'd5;
        step();
        idle();
        checks++;
        if (uop !== 20'hABCDE || ferr !== 1'b0) begin
            errors++;
            $display("FAIL err_clears: got uop=%h err=%b, want abcde 0", uop, ferr);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            fv   = ($urandom_range(0, 3) != 0);
            fad  = AW'($urandom_range(0, D + 8));
            hold = ($urandom_range(0, 4) == 0);
            lv   = ($urandom_range(0, 1) == 1);
            lb   = 1'($urandom);
            lad  = AW'($urandom_range(0, D + 3));
            ld   = UW'($urandom);
            sw   = ($urandom_range(0, 9) == 0);
            step();
            checks++;
            if ({uop, uval, ferr, act, done, fready, lready}
                !== {e_uop, e_val, e_err, m_act, m_done, m_done & ~hold, m_done}) begin
                errors++;
                $display("FAIL random cycle %0d: got uop=%h val=%b err=%b act=%b fr=%b, want %h %b %b %b %b",
                         i, uop, uval, ferr, act, fready, e_uop, e_val, e_err, m_act, ~hold);
            end
        end
        idle();
    endtask

    task automatic test_reset_midway();
        reset_and_check("run_reset");
        for (int i = 0; i < 10; i++) step();
        reset_and_check("init_reset");
        check_init("reinit1", 1'b0);
        lv  = 1'b1;
        lb  = 1'b0;
        lad = 8'd9;
        ld  = 20'h11111;
        step();
        idle();
        sw = 1'b1;
        step();
        idle();
        reset_and_check("loaded_reset");
        check_init("reinit2", 1'b0);
        fv  = 1'b1;
        fad = 8'd9;
        step();
        idle();
        checks++;
        if (uop !== NOP || uval !== 1'b1 || act !== 1'b0) begin
            errors++;
            $display("FAIL reinit_clear: got uop=%h val=%b act=%b, want %h 1 0", uop, uval, act, NOP);
        end
    endtask

    initial begin
        test_reset();
        test_init_clear();
        test_load_fetch();
        test_collision();
        test_swap();
        test_hold_oob();
        test_random();
        test_reset_midway();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
